// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - state codes shared by the serializer and the sequence-detector bench
package serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/bit_serializer_if.sv
// rtl/bit_serializer_if.sv - word load handshake between upstream and bit_serializer
interface bit_serializer_if #(
  parameter int WIDTH = 8
) ();

  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);

endinterface

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-in/serial-out stage, one bit per clk on x
module bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  bit_serializer_if.slave  ld,
  output logic             x,
  output logic             busy,
  output logic             done
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             x_q, x_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last;
  logic             accept;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign last          = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
  assign ld.load_ready = ~rst & ((state_q == ST_IDLE) | last);
  assign accept        = ld.load_valid & ld.load_ready;

  // The shift register holds only the bits not yet on x, so x stays a plain flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    x_d     = x_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (accept) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      x_d     = head(ld.load_data);
      sh_d    = advance(ld.load_data);
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else if ((state_q == ST_SHIFT) && !last) begin
      cnt_d   = cnt_q + CW'(1);
      x_d     = head(sh_q);
      sh_d    = advance(sh_q);
      busy_d  = 1'b1;
      done_d  = (cnt_d == LAST_CNT);
    end else begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sh_d    = '0;
      x_d     = IDLE_BIT;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      x_q     <= IDLE_BIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x    = x_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - directed vector bench for bit_serializer
module tb_bit_serializer;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       x;
    logic       busy;
    logic       done;
    logic       ready;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic x1, busy1, done1;
  logic x2, busy2, done2;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) ld1 ();
  bit_serializer_if #(.WIDTH(8)) ld2 ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut (
    .clk (clk), .rst (rst), .ld (ld1), .x (x1), .busy (busy1), .done (done1)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_msb (
    .clk (clk), .rst (rst), .ld (ld2), .x (x2), .busy (busy2), .done (done2)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic v, input logic [7:0] d,
                              input logic ex, input logic eb, input logic ed, input logic er);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d;
    t.x = ex; t.busy = eb; t.done = ed; t.ready = er;
    vecs.push_back(t);
  endfunction

  // Drive one cycle's inputs, check mid-cycle, then move to just after the next edge.
  task automatic cyc(input string tag, input logic r, input logic v, input logic [7:0] d,
                     input logic ex, input logic eb, input logic ed, input logic er);
    rst = r;
    ld1.load_valid = v;
    ld1.load_data  = d;
    @(negedge clk);
    chk({tag, ".x"},     x1,              ex);
    chk({tag, ".busy"},  busy1,           eb);
    chk({tag, ".done"},  done1,           ed);
    chk({tag, ".ready"}, ld1.load_ready,  er);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] w4d;
    logic [7:0] wc3;
    logic [7:0] w26;
    w4d = 8'h4D;
    wc3 = 8'hC3;
    w26 = 8'b0010_0110;

    // reset and idle
    for (int i = 0; i < 10; i++) add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)  add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // single word 8'h4D, LSB first
    add(1'b0, 1'b1, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++)
      add(1'b0, 1'b0, 8'h00, w4d[k], 1'b1, (k == 7), (k == 7));
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // back-to-back 8'hFF then 8'h00 held valid
    add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++)
      add(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, (k == 7), (k == 7));
    for (int k = 0; k < 8; k++)
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, (k == 7), (k == 7));
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    rst = 1'b1;
    ld1.load_valid = 1'b0; ld1.load_data = 8'h00;
    ld2.load_valid = 1'b0; ld2.load_data = 8'h00;
    @(posedge clk);
    #1;
    chk("msb_reset.x", x2, 1'b1);
    chk("msb_reset.busy", busy2, 1'b0);

    foreach (vecs[i])
      cyc($sformatf("vec%0d", i), vecs[i].rst, vecs[i].valid, vecs[i].data,
          vecs[i].x, vecs[i].busy, vecs[i].done, vecs[i].ready);

    // mid-word reset after the third bit of 8'hAA
    cyc("abort.acc", 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("abort.b0",  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("abort.b1",  1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("abort.b2",  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("abort.rst", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++)
      cyc($sformatf("abort.idle%0d", i), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // load offered mid-word is ignored; 8'hC3 completes unchanged
    cyc("ign.acc", 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++)
      cyc($sformatf("ign.b%0d", k), 1'b0, (k == 4), (k == 4) ? 8'h0F : 8'hC3,
          wc3[k], 1'b1, (k == 7), (k == 7));
    cyc("ign.idle0", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("ign.idle1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // MSB-first instance with IDLE_BIT=1
    rst = 1'b0;
    ld2.load_valid = 1'b1;
    ld2.load_data  = w26;
    @(negedge clk);
    chk("msb.ready", ld2.load_ready, 1'b1);
    chk("msb.idle_x", x2, 1'b1);
    @(posedge clk);
    #1;
    ld2.load_valid = 1'b0;
    ld2.load_data  = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("msb.b%0d.x", k), x2, w26[7-k]);
      chk($sformatf("msb.b%0d.busy", k), busy2, 1'b1);
      chk($sformatf("msb.b%0d.done", k), done2, (k == 7));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("msb.end.x", x2, 1'b1);
    chk("msb.end.busy", busy2, 1'b0);
    chk("msb.end.done", done2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
